// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// No logic; imported by the fetch stage, its queue and its interface.
// Entries carry the PC alongside the instruction word.
package riscv_fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage boundary: imem request/response, redirect, and decode handshake.
// master = fetch stage side, slave = memory/decode/branch environment side.
// Request and decode channels are valid/ready; responses are never backpressured.
interface fetch_stage_if;
    import riscv_fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO with flush and occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the producer must respect count (overflow asserts).
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !do_pop && !flush));
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited imem requests, PC-tagged queue to decode, redirect flush.
// Latency: response to dec_valid 1 cycle; 0 cycles via empty-queue bypass when FETCH_BYPASS_EN is defined.
// Backpressure: dec_ready low fills the queue, then credits stop new imem requests.
module fetch_stage
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]  CREDITS  = (CW+1)'(FIFO_DEPTH);
    localparam logic [1:0]   ST_BOOT  = 2'(BOOT);
    localparam logic [1:0]   ST_RUN   = 2'(RUN);
    localparam logic [1:0]   ST_DRAIN = 2'(DRAIN);

    logic [1:0]      state, state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding, out_next;
    logic [CW-1:0]   discard, discard_next;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    fetch_entry_t    fifo_head, rsp_entry, dec_entry;
    logic            redirect, req_fire, rsp_live, byp_vld, push, pop, dec_vld;

    assign redirect = bus.redirect_valid;
    assign bus.imem_req_valid = (state != ST_BOOT) &&
                                (({1'b0, fifo_count} + {1'b0, outstanding}) < CREDITS);
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

    // A response in a redirect cycle belongs to the old path even when discard is 0.
    assign rsp_live  = bus.imem_rsp_valid && (discard == '0) && !redirect;
    assign rsp_entry = '{pc: rsp_pc, instr: bus.imem_rsp_data};

`ifdef FETCH_BYPASS_EN
    assign byp_vld   = fifo_empty && rsp_live;
    assign push      = rsp_live && !(byp_vld && bus.dec_ready);
    assign dec_entry = fifo_empty ? rsp_entry : fifo_head;
`else
    assign byp_vld   = 1'b0;
    assign push      = rsp_live;
    assign dec_entry = fifo_head;
`endif

    assign dec_vld       = !fifo_empty || byp_vld;
    assign pop           = !fifo_empty && bus.dec_ready && !redirect;
    assign bus.dec_valid = dec_vld;
    assign bus.dec_instr = dec_vld ? dec_entry.instr : NOP_INSTR;
    assign bus.dec_pc    = dec_vld ? dec_entry.pc    : '0;

    assign out_next = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);

    always_comb begin
        discard_next = discard;
        if (redirect)
            discard_next = out_next;
        else if (bus.imem_rsp_valid && (discard != '0))
            discard_next = discard - CW'(1);
    end

    always_comb begin
        state_next = state;
        if (redirect)
            state_next = (out_next != '0) ? ST_DRAIN : ST_RUN;
        else if (state == ST_BOOT)
            state_next = ST_RUN;
        else if ((state == ST_DRAIN) && (discard_next == '0))
            state_next = ST_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_next;
            outstanding <= out_next;
            discard     <= discard_next;
            if (redirect) begin
                fetch_pc <= align_word(bus.redirect_pc);
                rsp_pc   <= align_word(bus.redirect_pc);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (rsp_live) rsp_pc   <= rsp_pc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (rsp_entry),
        .pop      (pop),
        .flush    (redirect),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: fixed-latency memory model plus an expected-decode scoreboard.
// Expected {pc, instr} pushed on each accepted request, cleared on redirect, compared on decode pops.
module tb_fetch_stage;
    import riscv_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_VLD_CYC = 2;
`else
    localparam int FIRST_VLD_CYC = 3;
`endif

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mem_req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_req_t    mem_q[$];
    logic [63:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc, first_vld, n_acc, lat;
    logic        redir, drdy, mrdy, chk_flush, arm_pop;
    logic [31:0] redir_pc, model_pc, first_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_req_vld"}, 32'(bus.imem_req_valid), 32'd0);
        check_eq({tag, "_req_addr"}, bus.imem_req_addr, RESET_PC);
        check_eq({tag, "_dec_vld"}, 32'(bus.dec_valid), 32'd0);
        check_eq({tag, "_dec_instr"}, bus.dec_instr, 32'h0000_0013);
        check_eq({tag, "_dec_pc"}, bus.dec_pc, 32'd0);
    endtask

    // One clock: drive at negedge, sample 1ns later, then advance to the next negedge.
    task automatic step();
        logic [63:0] e;
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir_pc;
        bus.dec_ready      = drdy;
        bus.imem_req_ready = mrdy;
        if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        #1;
        if (chk_flush) check_eq("flush_dec_vld", 32'(bus.dec_valid), 32'd0);
        chk_flush = 1'b0;
        if (bus.dec_valid && first_vld < 0) first_vld = cyc;
        if (!bus.dec_valid) check_eq("idle_nop", bus.dec_instr, NOP_INSTR);
        if (bus.dec_valid && drdy && !redir) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("dec_pc", bus.dec_pc, e[63:32]);
                check_eq("dec_instr", bus.dec_instr, e[31:0]);
            end
            if (arm_pop) begin
                first_pop = bus.dec_pc;
                arm_pop   = 1'b0;
            end
        end
        if (bus.imem_req_valid && mrdy) begin
            check_eq("req_addr", bus.imem_req_addr, model_pc);
            mem_q.push_back('{due: cyc + lat, addr: bus.imem_req_addr});
            exp_q.push_back({bus.imem_req_addr, mem_word(bus.imem_req_addr)});
            model_pc = model_pc + 32'd4;
            n_acc++;
        end
        if (redir) begin
            exp_q.delete();
            model_pc = {redir_pc[31:2], 2'b00};
        end
        @(negedge clk);
        cyc++;
        redir = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.dec_ready      = 1'b0;
        redir = 1'b0; redir_pc = 32'h0; drdy = 1'b1; mrdy = 1'b1;
        chk_flush = 1'b0; arm_pop = 1'b1; first_pop = 32'hDEAD_DEAD;
        mem_q.delete(); exp_q.delete();
        model_pc = RESET_PC; n_acc = 0; first_vld = -1; lat = 1;
        repeat (2) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic drain(input string tag);
        mrdy = 1'b0;
        drdy = 1'b1;
        repeat (12) step();
        check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        mrdy = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redir = 1'b1;
        redir_pc = pc;
        step();
        chk_flush = 1'b1;
        arm_pop = 1'b1;
        first_pop = 32'hDEAD_DEAD;
    endtask

    task automatic wait_outstanding(input int n);
        for (int k = 0; k < 10 && mem_q.size() < n; k++) step();
        check_eq("outstanding", 32'(mem_q.size()), 32'(n));
    endtask

    initial begin
        // Streaming from reset with a 1-cycle memory.
        do_reset();
        repeat (20) step();
        check_eq("t1_first_vld", 32'(first_vld), 32'(FIRST_VLD_CYC));
        check_eq("t1_first_pc", first_pop, RESET_PC);
        drain("t1");

        // Decode stalled: credits cap requests at the queue depth.
        do_reset();
        drdy = 1'b0;
        repeat (20) step();
        #1;
        check_eq("t2_accepts", 32'(n_acc), 32'(DEPTH));
        check_eq("t2_req_vld", 32'(bus.imem_req_valid), 32'd0);
        check_eq("t2_dec_vld", 32'(bus.dec_valid), 32'd1);
        check_eq("t2_head_pc", bus.dec_pc, 32'h0);
        drdy = 1'b1;
        repeat (10) step();
        drain("t2");

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        lat = 3;
        wait_outstanding(2);
        do_redirect(32'h0000_0100);
        repeat (15) step();
        check_eq("t3_first_pc", first_pop, 32'h0000_0100);
        drain("t3");

        // Redirect coinciding with a response and a decode pop.
        do_reset();
        repeat (10) step();
        check_eq("t4_rsp_due", 32'(mem_q.size() != 0 && mem_q[0].due == cyc), 32'd1);
        do_redirect(32'h0000_0200);
        repeat (10) step();
        check_eq("t4_first_pc", first_pop, 32'h0000_0200);
        drain("t4");

        // PC wrap and unaligned redirect target.
        do_reset();
        repeat (6) step();
        do_redirect(32'hFFFF_FFFC);
        repeat (10) step();
        check_eq("t5_wrap_pc", first_pop, 32'hFFFF_FFFC);
        do_redirect(32'h0000_0102);
        repeat (10) step();
        check_eq("t5_align_pc", first_pop, 32'h0000_0100);
        drain("t5");

        // Reset asserted while draining stale responses.
        do_reset();
        lat = 3;
        wait_outstanding(2);
        do_redirect(32'h0000_0300);
        rst_n = 1'b0;
        #1;
        check_reset("t6_mid");
        do_reset();
        lat = 3;
        repeat (15) step();
        check_eq("t6_restart_pc", first_pop, RESET_PC);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned instructions, with their PCs, in a small queue and presents them to decode over a valid/ready handshake.
- Accepts redirects from the branch comparator / jump logic, flushing queued and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction queue entries; power of 2, >= 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  instruction word returning; in order; >= 1 cycle after acceptance; never backpressured.
- imem_rsp_data  in  32  returned instruction word.
- redirect_valid  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  32  new PC; bits [1:0] ignored (treated as 0).
- dec_valid  out  1  instruction available to decode.
- dec_ready  in  1  decode consumes head this cycle.
- dec_instr  out  32  head instruction.
- dec_pc  out  32  PC of head instruction.

Behaviour:
- Reset (async, rst_n=0):
  - State BOOT; fetch PC = RESET_PC.
  - Queue empty; outstanding = 0; discard = 0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_instr=32'h0000_0013 (NOP), dec_pc=0.
- FSM:
  - BOOT -> RUN after one cycle; no request is issued in BOOT.
  - RUN -> DRAIN on redirect when stale responses are pending.
  - DRAIN -> RUN when discard reaches 0 with no new redirect.
  - RUN and DRAIN both issue requests.
- Request side:
  - imem_req_valid=1 iff state != BOOT and occupancy + outstanding < FIFO_DEPTH (credit rule; guarantees every response has a slot).
  - imem_req_addr = fetch PC.
  - On accept (valid & ready): fetch PC += 4 mod 2^32 (32'hFFFF_FFFC wraps to 0); outstanding += 1.
  - Memory samples the address only on the handshake cycle; the address may change while unaccepted.
- Response side:
  - Each imem_rsp_valid decrements outstanding.
  - If discard > 0: the response is dropped and discard decrements.
  - Otherwise {pc, instr} is pushed; the stored pc comes from an internal in-order PC tag queue or counter.
- Decode side:
  - Show-ahead: dec_valid = queue non-empty; dec_instr/dec_pc = head entry.
  - Pop on dec_valid & dec_ready.
  - When dec_valid=0, dec_instr holds the NOP value.
- Redirect at cycle t (highest priority):
  - Queue is cleared at the t edge, so dec_valid=0 in t+1 regardless of any dec_ready pop in t.
  - fetch PC = {redirect_pc[31:2],2'b00} in t+1.
  - discard_next = outstanding + (request accepted in t) - (response in t). A response arriving in t is dropped.
  - State -> DRAIN if discard_next > 0, else RUN.
  - A redirect arriving during DRAIN recomputes discard the same way.
  - A redirect during BOOT is honoured: it replaces RESET_PC.
- Boundaries:
  - A push at full is impossible by the credit rule; an assertion fires if it occurs.
  - Simultaneous push and pop keeps occupancy unchanged.
  - dec_ready held low stalls fetch once credit is exhausted.
  - Reset mid-operation abandons all state immediately.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When the queue is empty and a non-stale response arrives without a redirect, it drives dec_valid/dec_instr/dec_pc combinationally that cycle.
  - If dec_ready=1 it is consumed without being written; otherwise it is pushed.
  - Response-to-decode latency is 0 cycles.
- Undefined: every response is written first, giving a fixed 1-cycle latency from imem_rsp_valid to dec_valid.

Decomposition:
- Package riscv_fetch_pkg:
  - XLEN=32 and NOP_INSTR=32'h0000_0013.
  - fetch_state_t enum {BOOT, RUN, DRAIN}.
  - Entry struct {pc, instr}.
- Sub-module fetch_fifo: synchronous show-ahead FIFO with push/pop/flush, count output and an overflow assertion. Parameterized by depth and entry width.

Test Plan:
- Reset release, memory always ready, 1-cycle response -> requests to 0x0, 0x4, 0x8…; decode sees matching dec_pc; first dec_valid in cycle 3 after reset release (cycle 2 with FETCH_BYPASS_EN).
- dec_ready=0 for 20 cycles -> exactly 4 requests issued, then imem_req_valid=0; queue holds PCs 0x0-0xC in order; no loss after dec_ready=1.
- Redirect to 0x100 with 2 requests outstanding (3-cycle memory latency) -> both responses dropped; next dec_pc is 0x100; dec_valid=0 in cycle after redirect.
- Redirect in the same cycle as a response and a dec_ready pop -> response dropped, queue empty, refetch from redirect_pc; discard count correct.
- Redirect to 0xFFFF_FFFC -> dec_pc sequence 0xFFFF_FFFC, 0x0000_0000; redirect_pc=0x102 fetches 0x100.
- rst_n asserted mid-DRAIN with outstanding requests -> all outputs return to reset values immediately; fetch restarts at RESET_PC.
